// File: rtl/hazard_pkg.sv
// Shared types for the decode-stage hazard controller: forward-select codes,
// FSM state encoding and the destination-register shadow slot.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Register index width held in a shadow slot (MIPS register file index)
  localparam int unsigned SLOT_DST_W = 5;

  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } state_e;

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  mem_read;
    logic [SLOT_DST_W-1:0] dst;
  } slot_t;

  localparam slot_t SLOT_BUBBLE = '0;

endpackage

// File: rtl/hazard_slot_match.sv
// Compares one source register against one shadow slot.
// Ports:
//   slot       - shadow slot contents {valid, reg_write, mem_read, dst}
//   rsel       - source register index read by the ID instruction
//   used       - the ID instruction actually reads rsel
//   hit_c      - slot produces rsel (register $0 never matches)
//   load_hit_c - hit_c and the producer is a load
module hazard_slot_match
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W = 5
) (
  input  slot_t            slot,
  input  logic [REG_W-1:0] rsel,
  input  logic             used,
  output logic             hit_c,
  output logic             load_hit_c
);

  assign hit_c = used && slot.valid && slot.reg_write &&
                 (slot.dst == SLOT_DST_W'(rsel)) && (rsel != '0);
  assign load_hit_c = hit_c && slot.mem_read;

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard and sequencing controller for the 5-stage MIPS pipe.
// Tracks EX/MEM/WB destination state in shadow slots, resolves load-use and
// branch-compare hazards, selects branch-compare forwarding, redirects on
// taken branches and drains the pipe on an undefined-instruction trap.
// Ports:
//   clk, rst_n             - clock, async active-low reset
//   id_*                   - decoded fields of the instruction in IF/ID
//   pipe_stall             - bubble the ID control word
//   pc_write, ifid_write   - PC / IF/ID enables
//   ifid_flush             - zero IF/ID on the next edge
//   fwd_a, fwd_b           - compare-operand forward selects (rs / rt)
//   branch_taken           - select the branch target
//   trap                   - one-cycle pulse on trap entry
//   hazard_err             - sticky watchdog: too many consecutive stalls
//   perf_stall_cnt/_flush  - event counters
// Optional feature: define HAZARD_CTRL_PERF_EN to build the perf counters;
// otherwise the perf ports are tied to zero.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W     = 5,
  parameter int unsigned MAX_STALL = 3,
  parameter int unsigned PERF_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_is_branch,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic [REG_W-1:0]  id_dst,
  input  logic              id_equal,
  input  logic              id_bne,
  input  logic              id_undef,
  output logic              pipe_stall,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              branch_taken,
  output logic              trap,
  output logic              hazard_err,
  output logic [PERF_W-1:0] perf_stall_cnt,
  output logic [PERF_W-1:0] perf_flush_cnt
);

  localparam int unsigned RUN_W = $clog2(MAX_STALL + 1);

  slot_t            ex_q, mem_q, wb_q;
  state_e           state_q, state_d;
  logic [RUN_W-1:0] stall_run_q;

  logic [REG_W-1:0] src_reg [2];
  logic             src_used [2];
  logic             ex_hit [2], ex_ld [2], mem_hit [2], mem_ld [2];
  logic             wb_hit [2], unused_wb_ld [2];
  logic [1:0]       fwd_c [2];
  logic             stall_c, trap_enter_c, taken_c, issue_c, busy_c;

  assign src_reg[0]  = id_rs;
  assign src_reg[1]  = id_rt;
  assign src_used[0] = id_uses_rs;
  assign src_used[1] = id_uses_rt;

  // One comparator per slot/source pair
  for (genvar r = 0; r < 2; r++) begin : g_src
    hazard_slot_match #(.REG_W(REG_W)) u_ex (
      .slot(ex_q), .rsel(src_reg[r]), .used(src_used[r]),
      .hit_c(ex_hit[r]), .load_hit_c(ex_ld[r])
    );
    hazard_slot_match #(.REG_W(REG_W)) u_mem (
      .slot(mem_q), .rsel(src_reg[r]), .used(src_used[r]),
      .hit_c(mem_hit[r]), .load_hit_c(mem_ld[r])
    );
    hazard_slot_match #(.REG_W(REG_W)) u_wb (
      .slot(wb_q), .rsel(src_reg[r]), .used(src_used[r]),
      .hit_c(wb_hit[r]), .load_hit_c(unused_wb_ld[r])
    );
  end

  // A load in MEM has no data yet, so only a MEM ALU result may be forwarded
  always_comb begin : fwd_sel
    for (int r = 0; r < 2; r++) begin
      fwd_c[r] = FWD_RF;
      if (mem_hit[r] && !mem_q.mem_read) fwd_c[r] = FWD_MEM;
      else if (wb_hit[r])                fwd_c[r] = FWD_WB;
    end
  end

  // Hazard detection and issue decisions
  assign stall_c = (state_q == RUN) && id_valid &&
                   (ex_ld[0] || ex_ld[1] ||
                    (id_is_branch && (ex_hit[0] || ex_hit[1] || mem_ld[0] || mem_ld[1])));
  assign trap_enter_c = (state_q == RUN) && id_valid && id_undef && !stall_c;
  assign taken_c      = (state_q == RUN) && id_valid && id_is_branch && !stall_c &&
                        !id_undef && (id_equal ^ id_bne);
  assign issue_c      = (state_q == RUN) && id_valid && !stall_c && !trap_enter_c;
  assign busy_c       = ex_q.valid || mem_q.valid || wb_q.valid;

  // Next state and control outputs; everything idles to defaults under reset
  always_comb begin : ctrl
    state_d      = state_q;
    pipe_stall   = 1'b0;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    branch_taken = 1'b0;
    trap         = 1'b0;
    fwd_a        = FWD_RF;
    fwd_b        = FWD_RF;
    if (rst_n) begin
      fwd_a = fwd_c[0];
      fwd_b = fwd_c[1];
      unique case (state_q)
        RUN: begin
          if (stall_c) begin
            pipe_stall = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
          end else if (trap_enter_c) begin
            trap       = 1'b1;
            ifid_flush = 1'b1;
            pc_write   = 1'b0;
            state_d    = TRAP;
          end else if (taken_c) begin
            branch_taken = 1'b1;
            ifid_flush   = 1'b1;
          end
        end
        TRAP: begin
          // Drain older instructions; leave once every slot is empty
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          ifid_flush = 1'b1;
          pipe_stall = busy_c;
          if (!busy_c) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Shadow pipe, FSM state and stall watchdog
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= SLOT_BUBBLE;
      mem_q       <= SLOT_BUBBLE;
      wb_q        <= SLOT_BUBBLE;
      state_q     <= RUN;
      stall_run_q <= '0;
      hazard_err  <= 1'b0;
    end else begin
      wb_q    <= mem_q;
      mem_q   <= ex_q;
      ex_q    <= issue_c ? slot_t'{valid: 1'b1, reg_write: id_reg_write,
                                   mem_read: id_mem_read, dst: SLOT_DST_W'(id_dst)}
                         : SLOT_BUBBLE;
      state_q <= state_d;
      if (!stall_c)                                stall_run_q <= '0;
      else if (stall_run_q != RUN_W'(MAX_STALL))   stall_run_q <= stall_run_q + RUN_W'(1);
      if (stall_c && (stall_run_q >= RUN_W'(MAX_STALL - 1))) hazard_err <= 1'b1;
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  // Free-running event counters, wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (pipe_stall) perf_stall_cnt <= perf_stall_cnt + PERF_W'(1);
      if (ifid_flush) perf_flush_cnt <= perf_flush_cnt + PERF_W'(1);
    end
  end
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule
